// File: rtl/c7seg_pkg.sv
// Shared types, glyph table and polarity helpers for the multiplexed 7-segment driver.
package c7seg_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_DECODE = 2'd2
    } state_e;

    // Segment patterns in gfedcba order, 1 = lit, indexed by nibble value.
    localparam logic [6:0] GLYPH_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [7:0] seg_off(input logic active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [7:0] an_off(input logic active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/c7seg_if.sv
// Load handshake between a data producer and the multiplexed 7-segment driver.
interface c7seg_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load_s;
    logic [4*NUM_DIGITS-1:0]   data_s;
    logic [NUM_DIGITS-1:0]     dp_s;
    logic [NUM_DIGITS-1:0]     blank_s;
    logic                      wait_s;

    modport master (
        output load_s,
        output data_s,
        output dp_s,
        output blank_s,
        input  wait_s
    );

    modport slave (
        input  load_s,
        input  data_s,
        input  dp_s,
        input  blank_s,
        output wait_s
    );
endinterface

// File: rtl/c7seg_decode.sv
// Nibble to gfedcba glyph lookup; values above 9 go dark unless hex glyphs are enabled.
module c7seg_decode
    import c7seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       hex_mode_i,
    output logic [6:0] glyph_o
);

    // Table lookup with decimal-only blanking of A..F.
    always_comb begin
        if (!hex_mode_i && (nibble_i > 4'd9)) begin
            glyph_o = 7'h00;
        end else begin
            glyph_o = GLYPH_TAB[nibble_i];
        end
    end

endmodule

// File: rtl/c7seg_mux.sv
// Multi-digit 7-segment driver: captures a packed word via LOAD/WAIT and time-multiplexes
// the digits onto one segment bus with one-hot anode enables.
module c7seg_mux
    import c7seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int HEX_MODE       = 1,
    parameter int LZ_SUPPRESS    = 0,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    c7seg_if.slave                bus,
    output logic [7:0]            seg_o,
    output logic [NUM_DIGITS-1:0] an_o
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [7:0] SEG_OFF_V = seg_off(ACTIVE_LOW_SEG != 0);
    localparam logic [7:0] AN_OFF_ALL = an_off(ACTIVE_LOW_AN != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF_V = AN_OFF_ALL[NUM_DIGITS-1:0];

    state_e                  state_q, state_d;
    logic                    wait_q, wait_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    running_s;
    logic [NUM_DIGITS-1:0]   lz_mask_s;
    logic                    lz_run_s;
    logic [3:0]              cur_nib_s;
    logic [6:0]              glyph_s;
    logic [NUM_DIGITS-1:0]   an_on_s;

    assign running_s = en_i && (state_q != ST_INIT);
    assign cur_nib_s = act_data_q[{idx_q, 2'b00} +: 4];

    c7seg_decode u_decode (
        .nibble_i   (cur_nib_s),
        .hex_mode_i (HEX_MODE != 0),
        .glyph_o    (glyph_s)
    );

    // Leading-zero mask from the captured word; a lit decimal point ends the zero run.
    always_comb begin
        lz_mask_s = '0;
        lz_run_s  = (LZ_SUPPRESS != 0);
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lz_run_s && (sh_data_q[4*i +: 4] == 4'd0) && !sh_dp_q[i]) begin
                lz_mask_s[i] = 1'b1;
            end else begin
                lz_run_s = 1'b0;
            end
        end
    end

    // Refresh counter and digit index advance only while scanning is enabled.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (running_s) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                if (idx_q == IDX_MAX) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Load handshake FSM: capture into shadow registers, commit on the following edge.
    always_comb begin
        state_d     = state_q;
        sh_data_d   = sh_data_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        case (state_q)
            ST_INIT: begin
                if (en_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (en_i && bus.load_s) begin
                    sh_data_d  = bus.data_s;
                    sh_dp_d    = bus.dp_s;
                    sh_blank_d = bus.blank_s;
                    state_d    = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (en_i) begin
                    act_data_d  = sh_data_q;
                    act_dp_d    = sh_dp_q;
                    act_blank_d = sh_blank_q | lz_mask_s;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DECODE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        wait_d = (state_d != ST_IDLE);
    end

    // Output stage: XOR with the off pattern applies the configured polarity.
    always_comb begin
        an_on_s        = '0;
        an_on_s[idx_q] = 1'b1;
        if (running_s) begin
            seg_d = SEG_OFF_V ^ {act_dp_q[idx_q], (act_blank_q[idx_q] ? 7'h00 : glyph_s)};
            an_d  = AN_OFF_V ^ an_on_s;
        end else begin
            seg_d = SEG_OFF_V;
            an_d  = AN_OFF_V;
        end
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_INIT;
            wait_q      <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_data_q   <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '1;
            seg_q       <= SEG_OFF_V;
            an_q        <= AN_OFF_V;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_data_q   <= sh_data_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign bus.wait_s = wait_q;
    assign seg_o      = seg_q;
    assign an_o       = an_q;

endmodule
